// File: rtl/adc_spi_reader.sv
// adc_spi_reader
//   SPI master for an 8-channel 12-bit serial ADC (ADC128S022-style).
//   Each frame is 16 SCLK periods long. The channel address goes out on
//   ADC_SADDR and 16 bits come back on ADC_SDAT; the last 12 of them are the
//   result. The ADC converts the channel addressed in the previous frame, so
//   sample_chan reports the previous frame's address.
//
// Ports
//   clk           system clock
//   rst           asynchronous active-high reset
//   en            run continuous conversions while high
//   chan[2:0]     channel to address; latched when a frame starts
//   ADC_SCLK      serial clock to the ADC, idles high
//   ADC_CS_N      chip select, active low
//   ADC_SADDR     serial address to the ADC DIN pin
//   ADC_SDAT      serial data from the ADC DOUT pin
//   sample_out    last completed conversion result
//   sample_chan   channel that sample_out was converted from
//   sample_valid  one-cycle strobe when sample_out/sample_chan update
module adc_spi_reader #(
  parameter int CLK_DIV   = 8,  // clk cycles per SCLK half-period, >= 2
  parameter int FRAME_GAP = 4   // clk cycles with CS_N high between frames, >= 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [2:0]  chan,
  output logic        ADC_SCLK,
  output logic        ADC_CS_N,
  output logic        ADC_SADDR,
  input  logic        ADC_SDAT,
  output logic [11:0] sample_out,
  output logic [2:0]  sample_chan,
  output logic        sample_valid
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);

  typedef enum logic [2:0] {IDLE, START, SHIFT, DONE, GAP} state_t;

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
  logic [5:0]        tog_cnt_reg, tog_cnt_next;    // SCLK toggles done this frame
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic              sclk_reg, sclk_next;
  logic              cs_n_reg, cs_n_next;
  logic              saddr_reg, saddr_next;
  logic              valid_reg, valid_next;
  logic [11:0]       sample_reg, sample_next;
  logic [2:0]        schan_reg, schan_next;
  logic [2:0]        prev_chan_reg, prev_chan_next;
  logic [2:0]        frame_addr_reg, frame_addr_next;
  // Only the low 12 bits of the 16-bit frame are kept; the four leading
  // bits shift straight out of the top and are never looked at.
  logic [11:0]       shreg_reg, shreg_next;

  logic              shifting, div_wrap, is_fall, is_rise, frame_end;
  logic              frame_start, gap_last;
  logic [5:0]        tog_k;        // number of the toggle due at this wrap
  logic [3:0]        addr_idx;
  logic [15:0]       frame_word;

  assign shifting   = (state_reg == START) || (state_reg == SHIFT);
  assign div_wrap   = shifting && (div_cnt_reg == DIV_LAST);
  assign tog_k      = tog_cnt_reg + 6'd1;
  // Toggles 1..32 drive SCLK; odd ones fall, even ones rise. Toggle 33 is
  // the end of the final high half-period and closes the frame.
  assign is_fall    = div_wrap && (tog_k <= 6'd32) && tog_k[0];
  assign is_rise    = div_wrap && (tog_k <= 6'd32) && !tog_k[0];
  assign frame_end  = div_wrap && (tog_k == 6'd33);
  assign gap_last   = (gap_cnt_reg == GAP_LAST);
  assign frame_word = {2'b00, frame_addr_reg, 11'b0};
  // Falling edge n sends bit 16-n; with tog_cnt even, n = tog_cnt/2 + 1.
  assign addr_idx   = 4'd15 - tog_cnt_reg[4:1];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (en) state_next = START;
      START:   if (div_wrap) state_next = SHIFT;
      SHIFT:   if (frame_end) state_next = DONE;
      DONE:    state_next = GAP;
      GAP:     if (gap_last) state_next = en ? START : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign frame_start = ((state_reg == IDLE) || (state_reg == GAP)) &&
                       (state_next == START);

  // Output / datapath next values
  always_comb begin
    sclk_next       = sclk_reg;
    cs_n_next       = cs_n_reg;
    saddr_next      = saddr_reg;
    valid_next      = 1'b0;
    sample_next     = sample_reg;
    schan_next      = schan_reg;
    prev_chan_next  = prev_chan_reg;
    frame_addr_next = frame_addr_reg;
    shreg_next      = shreg_reg;
    div_cnt_next    = div_cnt_reg;
    tog_cnt_next    = tog_cnt_reg;
    gap_cnt_next    = gap_cnt_reg;

    if (frame_start) begin
      cs_n_next       = 1'b0;
      sclk_next       = 1'b1;
      saddr_next      = 1'b0;
      frame_addr_next = chan;
      div_cnt_next    = '0;
      tog_cnt_next    = '0;
    end

    if (shifting) begin
      div_cnt_next = div_wrap ? '0 : div_cnt_reg + 1'b1;
      if (div_wrap) tog_cnt_next = tog_k;
      if (is_fall) begin
        sclk_next  = 1'b0;
        saddr_next = frame_word[addr_idx];
      end
      if (is_rise) begin
        // Capture DOUT on the same clk edge that raises SCLK.
        sclk_next  = 1'b1;
        shreg_next = {shreg_reg[10:0], ADC_SDAT};
      end
      if (frame_end) begin
        cs_n_next      = 1'b1;
        saddr_next     = 1'b0;
        valid_next     = 1'b1;
        sample_next    = shreg_reg;
        // The result belongs to the address sent one frame earlier.
        schan_next     = prev_chan_reg;
        prev_chan_next = frame_addr_reg;
      end
    end

    if (state_reg == DONE) gap_cnt_next = '0;
    if (state_reg == GAP)  gap_cnt_next = gap_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_reg       <= 1'b1;
      cs_n_reg       <= 1'b1;
      saddr_reg      <= 1'b0;
      valid_reg      <= 1'b0;
      sample_reg     <= '0;
      schan_reg      <= '0;
      prev_chan_reg  <= '0;
      frame_addr_reg <= '0;
      shreg_reg      <= '0;
      div_cnt_reg    <= '0;
      tog_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
    end else begin
      sclk_reg       <= sclk_next;
      cs_n_reg       <= cs_n_next;
      saddr_reg      <= saddr_next;
      valid_reg      <= valid_next;
      sample_reg     <= sample_next;
      schan_reg      <= schan_next;
      prev_chan_reg  <= prev_chan_next;
      frame_addr_reg <= frame_addr_next;
      shreg_reg      <= shreg_next;
      div_cnt_reg    <= div_cnt_next;
      tog_cnt_reg    <= tog_cnt_next;
      gap_cnt_reg    <= gap_cnt_next;
    end
  end

  assign ADC_SCLK     = sclk_reg;
  assign ADC_CS_N     = cs_n_reg;
  assign ADC_SADDR    = saddr_reg;
  assign sample_out   = sample_reg;
  assign sample_chan  = schan_reg;
  assign sample_valid = valid_reg;

endmodule

// File: tb/tb_adc_spi_reader.sv
// tb_adc_spi_reader
//   Self-checking bench for adc_spi_reader with CLK_DIV=2, FRAME_GAP=4.
//   An ADC model drives DOUT on SCLK falling edges and records DIN on rising
//   edges. Expected samples are queued when a frame is set up and compared
//   when sample_valid pulses.
module tb_adc_spi_reader;

  localparam int CLK_DIV   = 2;
  localparam int FRAME_GAP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [2:0]  chan = 3'd0;
  logic        ADC_SDAT = 1'b0;
  logic        ADC_SCLK, ADC_CS_N, ADC_SADDR;
  logic [11:0] sample_out;
  logic [2:0]  sample_chan;
  logic        sample_valid;

  adc_spi_reader #(.CLK_DIV(CLK_DIV), .FRAME_GAP(FRAME_GAP)) dut (
    .clk(clk), .rst(rst), .en(en), .chan(chan),
    .ADC_SCLK(ADC_SCLK), .ADC_CS_N(ADC_CS_N), .ADC_SADDR(ADC_SADDR),
    .ADC_SDAT(ADC_SDAT), .sample_out(sample_out), .sample_chan(sample_chan),
    .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Scoreboard queues
  logic [14:0] exp_q[$];        // {sample_chan, sample_out}
  logic [15:0] model_q[$];      // words the ADC model returns, one per frame
  logic [15:0] exp_din_q[$];    // DIN pattern expected per frame
  int          valid_cyc_q[$];
  logic [2:0]  tb_prev_chan = 3'd0;

  task automatic queue_frame(input logic [2:0] c, input logic [15:0] w);
    model_q.push_back(w);
    exp_q.push_back({tb_prev_chan, w[11:0]});
    exp_din_q.push_back({2'b00, c, 11'b0});
    tb_prev_chan = c;
  endtask

  // ADC model
  logic        sclk_q = 1'b1;
  logic        csn_q = 1'b1;
  logic [15:0] tx_word = 16'h0;
  logic [15:0] din_bits = 16'h0;
  logic [15:0] din_exp;
  int          fall_cnt = 0;
  int          rise_cnt = 0;

  always @(ADC_SCLK or ADC_CS_N) begin
    if (csn_q && !ADC_CS_N) begin
      fall_cnt = 0;
      rise_cnt = 0;
      din_bits = 16'h0;
      if (model_q.size() != 0) tx_word = model_q.pop_front();
      else tx_word = 16'h0;
    end else if (!csn_q && ADC_CS_N) begin
      if (!rst) begin
        check_val("sclk_falls", fall_cnt, 16);
        check_val("sclk_rises", rise_cnt, 16);
        if (exp_din_q.size() != 0) begin
          din_exp = exp_din_q.pop_front();
          check_val("din_bits", din_bits, din_exp);
        end
      end
    end else if (ADC_CS_N == 1'b0) begin
      if (sclk_q && !ADC_SCLK && fall_cnt < 16) begin
        fall_cnt++;
        ADC_SDAT = tx_word[16 - fall_cnt];
      end else if (!sclk_q && ADC_SCLK) begin
        rise_cnt++;
        din_bits = {din_bits[14:0], ADC_SADDR};
      end
    end
    sclk_q = ADC_SCLK;
    csn_q  = ADC_CS_N;
  end

  // Output monitor
  int          cs_fall_cyc = 0;
  int          cs_fall_count = 0;
  int          valid_count = 0;
  logic        csn_mon = 1'b1;
  logic        valid_prev = 1'b0;
  logic [14:0] e;

  always @(negedge clk) begin
    if (csn_mon && ADC_CS_N == 1'b0) begin
      cs_fall_cyc = cyc;
      cs_fall_count++;
    end
    csn_mon = ADC_CS_N;
    if (sample_valid === 1'b1) begin
      $display("sample chan %0d data %03h at cycle %0d", sample_chan, sample_out, cyc);
      check_val("valid_width", 32'(valid_prev), 0);
      check_val("valid_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val("sample_out", 32'(sample_out), 32'(e[11:0]));
        check_val("sample_chan", 32'(sample_chan), 32'(e[14:12]));
      end
      valid_cyc_q.push_back(cyc);
      valid_count++;
    end
    valid_prev = (sample_valid === 1'b1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_cs_count(input int target, input int budget);
    int k = 0;
    while (cs_fall_count < target && k < budget) begin
      @(negedge clk); #1; k++;
    end
    check_val("cs_fall_seen", 32'(cs_fall_count >= target), 1);
  endtask

  task automatic wait_valid_count(input int target, input int budget);
    int k = 0;
    while (valid_count < target && k < budget) begin
      @(negedge clk); #1; k++;
    end
    check_val("valid_seen", 32'(valid_count >= target), 1);
  endtask

  // Continuous burst of n frames; chan changes mid-frame for the next one.
  logic [2:0]  b_ch[3];
  logic [15:0] b_wd[3];
  int          en_cyc = 0;

  task automatic run_burst(input int n);
    int cs0;
    int v0;
    cs0 = cs_fall_count;
    v0  = valid_count;
    for (int i = 0; i < n; i++) queue_frame(b_ch[i], b_wd[i]);
    chan   = b_ch[0];
    en     = 1'b1;
    en_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      wait_cs_count(cs0 + i + 1, 100);
      if (i + 1 < n) chan = b_ch[i + 1];
      else en = 1'b0;
    end
    wait_valid_count(v0 + n, 100);
    wait_cycles(10);
  endtask

  initial begin
    int cs0;
    int v0;
    int k;
    int n;

    // Reset state
    rst = 1'b1;
    wait_cycles(3);
    check_val("rst_sclk", 32'(ADC_SCLK), 1);
    check_val("rst_cs_n", 32'(ADC_CS_N), 1);
    check_val("rst_saddr", 32'(ADC_SADDR), 0);
    check_val("rst_sample_out", 32'(sample_out), 0);
    check_val("rst_sample_chan", 32'(sample_chan), 0);
    check_val("rst_valid", 32'(sample_valid), 0);
    rst = 1'b0;
    wait_cycles(3);

    // 1: single frame, channel 0, data ABC
    b_ch = '{3'd0, 3'd0, 3'd0};
    b_wd = '{16'h0ABC, 16'h0, 16'h0};
    run_burst(1);
    check_val("cs_after_en", cs_fall_cyc - en_cyc, 1);
    check_val("valid_latency", valid_cyc_q[valid_cyc_q.size() - 1] - cs_fall_cyc, 66);

    // 2+3: continuous frames chan 2, 5, 7 returning the channel index
    b_ch = '{3'd2, 3'd5, 3'd7};
    b_wd = '{16'h0002, 16'h0005, 16'h0007};
    run_burst(3);
    n = valid_cyc_q.size();
    check_val("valid_spacing_a", valid_cyc_q[n - 2] - valid_cyc_q[n - 3], 71);
    check_val("valid_spacing_b", valid_cyc_q[n - 1] - valid_cyc_q[n - 2], 71);

    // 4: all ones including leading bits, then MSB-only data
    b_ch = '{3'd1, 3'd6, 3'd0};
    b_wd = '{16'hFFFF, 16'h0800, 16'h0};
    run_burst(2);

    // 5: en dropped at SCLK falling edge 5
    cs0 = cs_fall_count;
    v0  = valid_count;
    queue_frame(3'd3, 16'h0A5A);
    chan = 3'd3;
    en   = 1'b1;
    wait_cs_count(cs0 + 1, 100);
    k = 0;
    while (fall_cnt < 5 && k < 40) begin
      @(negedge clk); #1; k++;
    end
    check_val("fall5_reached", 32'(fall_cnt), 5);
    en = 1'b0;
    wait_valid_count(v0 + 1, 100);
    wait_cycles(150);
    check_val("endrop_pulses", valid_count - v0, 1);
    check_val("endrop_frames", cs_fall_count - cs0, 1);
    check_val("endrop_cs_n", 32'(ADC_CS_N), 1);
    check_val("endrop_sclk", 32'(ADC_SCLK), 1);

    // 6: reset at SCLK rising edge 8
    cs0 = cs_fall_count;
    v0  = valid_count;
    queue_frame(3'd4, 16'h0555);
    chan = 3'd4;
    en   = 1'b1;
    wait_cs_count(cs0 + 1, 100);
    k = 0;
    while (rise_cnt < 8 && k < 60) begin
      @(negedge clk); #1; k++;
    end
    check_val("rise8_reached", 32'(rise_cnt), 8);
    rst = 1'b1;
    #1;
    check_val("midrst_cs_n", 32'(ADC_CS_N), 1);
    check_val("midrst_sclk", 32'(ADC_SCLK), 1);
    check_val("midrst_saddr", 32'(ADC_SADDR), 0);
    check_val("midrst_sample_out", 32'(sample_out), 0);
    check_val("midrst_sample_chan", 32'(sample_chan), 0);
    check_val("midrst_valid", 32'(sample_valid), 0);
    exp_q.delete();
    exp_din_q.delete();
    model_q.delete();
    tb_prev_chan = 3'd0;
    wait_cycles(3);
    queue_frame(3'd5, 16'h0321);
    chan = 3'd5;
    rst  = 1'b0;
    wait_cs_count(cs0 + 2, 100);
    en = 1'b0;
    wait_valid_count(v0 + 1, 100);
    wait_cycles(10);
    check_val("rst_frame_pulses", valid_count - v0, 1);
    check_val("exp_q_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
